// File: rtl/wb_sram_slave.sv
// Wishbone B4 pipelined slave: word-addressed SRAM with byte-lane writes and WaitStates stall cycles.
// Optional macro WB_SRAM_SLAVE_ADDR_CHECK_EN: requests outside the window terminate with err.
module wb_sram_slave #(
   parameter int unsigned Depth      = 1024,
   parameter int unsigned WaitStates = 0,
   parameter logic [31:0] BaseAddr   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cyc,
   input  logic        stb,
   input  logic        we,
   input  logic [3:0]  sel,
   input  logic [31:0] adr,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   output logic        ack,
   output logic        err,
   output logic        stall
);
   localparam int unsigned AW = $clog2(Depth);

   logic [31:0]   mem [Depth];
   logic [31:0]   offs;
   logic [AW-1:0] req_idx;
   logic          req_oob;
   logic          accept;

   // Response-edge view of the transaction, either live (no wait states) or latched.
   logic          resp_fire;
   logic          rsp_we;
   logic [3:0]    rsp_sel;
   logic [31:0]   rsp_dat;
   logic [AW-1:0] rsp_idx;
   logic          rsp_oob;

   assign offs    = adr - BaseAddr;
   assign req_idx = offs[AW+1:2];
   assign accept  = cyc & stb & ~stall;

`ifdef WB_SRAM_SLAVE_ADDR_CHECK_EN
   localparam logic [31:0] WinBytes = 32'(Depth * 4);
   logic unused_bits;
   assign req_oob     = (offs >= WinBytes);
   assign unused_bits = ^offs[1:0];
`else
   // Bits above the window are dropped, so out-of-window addresses alias.
   logic unused_bits;
   assign req_oob     = 1'b0;
   assign unused_bits = ^{offs[31:AW+2], offs[1:0]};
`endif

   generate
      if (WaitStates == 0) begin : g_no_wait
         assign stall     = 1'b0;
         assign resp_fire = accept & ~rst;
         assign rsp_we    = we;
         assign rsp_sel   = sel;
         assign rsp_dat   = dat_i;
         assign rsp_idx   = req_idx;
         assign rsp_oob   = req_oob;
      end else begin : g_wait
         typedef enum logic {IDLE, BUSY} state_t;
         localparam logic [3:0] CntInit = 4'(WaitStates - 1);

         state_t        state;
         logic [3:0]    cnt;
         logic          we_q;
         logic [3:0]    sel_q;
         logic [31:0]   dat_q;
         logic [AW-1:0] idx_q;
         logic          oob_q;

         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state <= IDLE;
               stall <= 1'b0;
               cnt   <= '0;
               we_q  <= 1'b0;
               sel_q <= '0;
               dat_q <= '0;
               idx_q <= '0;
               oob_q <= 1'b0;
            end else begin
               case (state)
                  IDLE: if (accept) begin
                     state <= BUSY;
                     stall <= 1'b1;
                     cnt   <= CntInit;
                     we_q  <= we;
                     sel_q <= sel;
                     dat_q <= dat_i;
                     idx_q <= req_idx;
                     oob_q <= req_oob;
                  end
                  BUSY: if (!cyc || cnt == 4'd0) begin
                     // Dropping cyc abandons the transaction without a termination.
                     state <= IDLE;
                     stall <= 1'b0;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
                  default: state <= IDLE;
               endcase
            end
         end

         assign resp_fire = (state == BUSY) & cyc & (cnt == 4'd0);
         assign rsp_we    = we_q;
         assign rsp_sel   = sel_q;
         assign rsp_dat   = dat_q;
         assign rsp_idx   = idx_q;
         assign rsp_oob   = oob_q;
      end
   endgenerate

   // NOTE: the memory array has no reset; clearing it would defeat RAM inference and is not required.
   always_ff @(posedge clk) begin
      if (resp_fire && rsp_we && !rsp_oob) begin
         for (int b = 0; b < 4; b++) begin
            if (rsp_sel[b]) mem[rsp_idx][8*b +: 8] <= rsp_dat[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack   <= 1'b0;
         err   <= 1'b0;
         dat_o <= '0;
      end else begin
         ack <= resp_fire & ~rsp_oob;
         err <= resp_fire & rsp_oob;
         if (resp_fire && !rsp_we && !rsp_oob) dat_o <= mem[rsp_idx];
      end
   end
endmodule
